mem_arbiter: RTL
================

# mem_arbiter

Shares the core's single-port unified memory between the instruction-fetch path (PC / `iaddr`) and the load/store path. It issues at most one access per cycle, favours data accesses with a bounded starvation guard for fetch, and routes read data back to the owning requester after a fixed memory latency. The block sits between the core controller/LSU and the memory macro. The core stalls on a missing grant.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles from an accepted read to `m_rdata` being valid. Legal range 1..4.
- `STARVE_MAX`, default 4: number of consecutive denied fetch cycles after which fetch is forced to win. Legal range 1..15.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request. Held, with `i_addr` stable, until granted.
- `i_addr`  in  30  fetch word address.
- `i_gnt`  out  1  fetch accepted this cycle. Combinational.
- `i_rvalid`  out  1  fetch data valid.
- `i_rdata`  out  32  fetch data.
- `d_req`  in  1  data request. Held, with all `d_*` inputs stable, until granted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  30  data word address.
- `d_wdata`  in  32  store data.
- `d_be`  in  4  store byte enables.
- `d_gnt`  out  1  data accepted this cycle. Combinational.
- `d_rvalid`  out  1  load data valid.
- `d_rdata`  out  32  load data.
- `m_en`  out  1  memory access this cycle.
- `m_we`  out  1  memory write.
- `m_addr`  out  30  memory word address.
- `m_wdata`  out  32  memory write data.
- `m_be`  out  4  memory byte enables.
- `m_rdata`  in  32  memory read data. Valid `MEM_LAT` cycles after a read is issued.

## Operation
- **Acceptance:** a request is accepted in cycle N when `req` and `gnt` are both high in N. Only one of `i_gnt` / `d_gnt` may be high in any cycle.
- **Priority:** `d_req` wins unless `force_i` is set.
  - `force_i` = (`starve_cnt` == `STARVE_MAX`).
  - With no competing request, the lone requester is granted.
- **Starvation counter** (`starve_cnt`, 4 bits):
  - Increments in any cycle with `i_req` high and `i_gnt` low.
  - Saturates at `STARVE_MAX`.
  - Clears in any cycle with `i_gnt` high, or with `i_req` low.
- **Memory drive:**
  - On a grant: `m_en` = 1, `m_addr` = the winner's address. If the winner is data, `m_we` = `d_we`, `m_wdata` = `d_wdata`, `m_be` = `d_be`. If the winner is fetch, `m_we` = 0 and `m_be` = 4'b1111.
  - With no grant: `m_en` = 0, `m_we` = 0, and the other `m_*` outputs are don't-care (implementation drives 0).
- **Tag pipeline:**
  - A shift register `MEM_LAT` entries deep, each entry {valid, owner}.
  - Stage 0 is loaded with {1, owner} for an accepted read, and with {0, x} for a store or no grant.
  - Shifts every cycle.
  - The last stage drives the return: `i_rvalid` = valid & owner==I, `d_rvalid` = valid & owner==D.
  - `i_rdata` and `d_rdata` both pass `m_rdata` combinationally. They are meaningful only when the matching `rvalid` is high.
- **Stores:** complete at issue and never produce `d_rvalid`.
- **Back-to-back:** one accepted access per cycle is sustained indefinitely. Returns stay in issue order.

## Timing
- **Reset:**
  - Tag pipeline valid bits clear and `starve_cnt` = 0.
  - All outputs read 0 during the reset cycle and in the cycle after it: no grants, `m_en` = 0, no `rvalid`.
  - Reads in flight at reset are dropped and never return `rvalid`, even though memory may still return data.
- **Read latency:** accepted in cycle N → `rvalid` high in cycle N+`MEM_LAT` for exactly one cycle.
- **Grant timing:**
  - `gnt` is a function of the current `req` inputs and `starve_cnt` only.
  - `gnt` never depends on `m_rdata` or on the tag pipeline.
- **Simultaneous events:**
  - `d_req` and `i_req` high with `force_i` = 0 → `d_gnt`.
  - Same requests with `force_i` = 1 → `i_gnt`, then `starve_cnt` → 0.
- **Return/issue overlap:** a return and a new issue in the same cycle are independent. No bubble is inserted.
- **Request withdrawal:** a requester that drops `req` before its grant is simply not served. No state is held for it.

## Test plan
1. **Lone fetch:** `MEM_LAT`=1, `i_req`=1, `i_addr`=0x10 in cycle 2, memory returns 0xDEADBEEF → `i_gnt`=1 and `m_addr`=0x10, `m_we`=0 in cycle 2; `i_rvalid`=1 with `i_rdata`=0xDEADBEEF in cycle 3; `d_rvalid` stays 0.
2. **Contention:** `i_req` and `d_req` (load, `d_addr`=0x20) both high in cycle 5 → `d_gnt`=1, `i_gnt`=0, `m_addr`=0x20, `starve_cnt`=1 after the edge.
3. **Starvation:** `STARVE_MAX`=4, `d_req` and `i_req` held high continuously → `d_gnt` in 4 consecutive cycles, `i_gnt` in the 5th, then `d_gnt` resumes; the pattern repeats every 5 cycles.
4. **Store:** `d_we`=1, `d_addr`=0x3, `d_wdata`=0x12345678, `d_be`=4'b0011 → `m_en`=`m_we`=1 with matching `m_wdata`/`m_be` that cycle; no `d_rvalid` during the following 4 cycles.
5. **Pipelined routing:** `MEM_LAT`=3, issue I, D(load), D(store), I in cycles 1–4 → `i_rvalid` in cycle 4, `d_rvalid` in cycle 5, nothing in cycle 6, `i_rvalid` in cycle 7.
6. **Reset mid-flight:** `MEM_LAT`=2, fetch accepted in cycle 3, `reset` high in cycle 4 → no `i_rvalid` in cycle 5; `starve_cnt`=0; grants resume in cycle 6 for requests held high.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port memory between instruction fetch and
// load/store, data-first with a starvation guard for fetch, and routes read
// data back to the owning requester after MEM_LAT cycles.
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata
);

  localparam int LAST = MEM_LAT - 1;

  logic [3:0]         starve_cnt;
  logic               rst_q;
  logic               blocked;
  logic               force_i;
  logic               rd_acc;
  logic [MEM_LAT-1:0] tag_v;
  logic [MEM_LAT-1:0] tag_d;

  // Grants are held off in the reset cycle and the cycle right after it.
  assign blocked = reset | rst_q;
  assign force_i = (starve_cnt == 4'(STARVE_MAX));
  assign rd_acc  = i_gnt | (d_gnt & ~d_we);

  // Grant selection: data first unless fetch has starved long enough.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!blocked) begin
      if (i_req && (force_i || !d_req)) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Drive the memory port from the winning requester.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    if (i_gnt) begin
      m_en   = 1'b1;
      m_addr = i_addr;
      m_be   = 4'b1111;
    end else if (d_gnt) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_be    = d_be;
    end
  end

  // Remember that reset was asserted last cycle.
  always_ff @(posedge clk) begin
    rst_q <= reset;
  end

  // Count consecutive denied fetch cycles, saturating at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (i_req && !i_gnt) begin
      if (!force_i) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Tag pipeline: {valid, owner} per issued read, owner 1 = data.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v <= '0;
      tag_d <= '0;
    end else begin
      tag_v[0] <= rd_acc;
      tag_d[0] <= d_gnt;
      for (int s = 1; s < MEM_LAT; s++) begin
        tag_v[s] <= tag_v[s-1];
        tag_d[s] <= tag_d[s-1];
      end
    end
  end

  assign i_rvalid = ~reset & tag_v[LAST] & ~tag_d[LAST];
  assign d_rvalid = ~reset & tag_v[LAST] &  tag_d[LAST];
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule
